apb_bridge_multi: RTL and testbench

Parametrised APB master bridge that converts a simple valid/ready request interface into APB3 transfers toward up to NUM_SLAVES peripherals. It is the next generation of the single-slave bridge: widths are parametric, addresses are decoded to one-hot select lines, slaves may insert wait states and signal errors, and a watchdog aborts stalled transfers. It sits between the system-side request master and the peripheral APB fabric.

---
 rtl/apb_bridge_multi.sv | 145 ++++++++++++++
 tb/tb_apb_bridge_multi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_multi.sv
// APB3 master bridge: valid/ready requests to up to NUM_SLAVES peripherals,
// with one-hot address decode, wait-state support, slave errors and a stall watchdog.
module apb_bridge_multi #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                             pclk,
   input  logic                             preset_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   input  logic [DATA_WIDTH-1:0]            req_wdata,
   output logic                             rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             rsp_err,
   output logic [NUM_SLAVES-1:0]            psel,
   output logic                             penable,
   output logic                             pwrite,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic [DATA_WIDTH-1:0]            pwdata,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]            pready,
   input  logic [NUM_SLAVES-1:0]            pslverr
);

   localparam int unsigned SEL_BITS = $clog2(NUM_SLAVES);
   localparam int unsigned CNT_RAW  = $clog2(TIMEOUT + 1);
   localparam int unsigned CNT_W    = (CNT_RAW < 1) ? 1 : CNT_RAW;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   state_e                  state_q;
   logic [CNT_W-1:0]        wait_q;
   logic [CNT_W-1:0]        wait_d;
   logic [NUM_SLAVES-1:0]   psel_q;
   logic                    penable_q;
   logic                    pwrite_q;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic                    rsp_valid_q;
   logic                    rsp_err_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;

   logic [SEL_BITS-1:0]     req_idx;
   logic [SEL_BITS-1:0]     cur_idx;
   logic [NUM_SLAVES-1:0]   req_onehot;
   logic                    cur_ready;
   logic                    cur_err;
   logic [DATA_WIDTH-1:0]   cur_rdata;
   logic                    timeout_hit;

   assign req_idx = req_addr[ADDR_WIDTH-1 -: SEL_BITS];
   assign cur_idx = paddr_q[ADDR_WIDTH-1 -: SEL_BITS];
   assign wait_d  = wait_q + 1'b1;

   // Only the addressed slave's ready/error/data are observed.
   always_comb begin
      req_onehot = '0;
      cur_ready  = 1'b0;
      cur_err    = 1'b0;
      cur_rdata  = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         req_onehot[i] = (req_idx == SEL_BITS'(i));
         if (cur_idx == SEL_BITS'(i)) begin
            cur_ready = pready[i];
            cur_err   = pslverr[i];
            cur_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign timeout_hit = (TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT));

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  pwrite_q <= req_write;
                  paddr_q  <= req_addr;
                  pwdata_q <= req_wdata;
                  psel_q   <= req_onehot;
                  wait_q   <= '0;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (cur_ready) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= cur_err;
                  rsp_rdata_q <= pwrite_q ? '0 : cur_rdata;
                  psel_q      <= '0;
                  penable_q   <= 1'b0;
                  state_q     <= IDLE;
               end else if (timeout_hit) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  psel_q      <= '0;
                  penable_q   <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  wait_q <= wait_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = preset_n && (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_bridge_multi.sv
// Self-checking bench for apb_bridge_multi: directed and random transfers against
// a transaction-level model of latency, select, response data and error.
module tb_apb_bridge_multi;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned NS = 4;
   localparam int unsigned TO = 15;

   logic              pclk;
   logic              preset_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [AW-1:0]     req_addr;
   logic [DW-1:0]     req_wdata;
   logic              rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic [NS-1:0]     psel;
   logic              penable;
   logic              pwrite;
   logic [AW-1:0]     paddr;
   logic [DW-1:0]     pwdata;
   logic [NS*DW-1:0]  prdata;
   logic [NS-1:0]     pready;
   logic [NS-1:0]     pslverr;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   apb_bridge_multi #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_SLAVES (NS),
      .TIMEOUT    (TO)
   ) dut (
      .pclk      (pclk),
      .preset_n  (preset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: observed no finish, required finish before limit");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_noise();
      for (int i = 0; i < int'(NS); i++) begin
         pready[i]           = 1'($urandom);
         pslverr[i]          = 1'($urandom);
         prdata[i*DW +: DW]  = 16'($urandom);
      end
   endtask

   // Random traffic on every slave, then the addressed slave is overridden.
   task automatic drive_slave(input int unsigned idx, input bit rdy, input bit err,
                              input logic [DW-1:0] data);
      drive_noise();
      pready[idx]            = rdy;
      pslverr[idx]           = err;
      prdata[idx*DW +: DW]   = data;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_psel"},    32'(psel),      32'h0);
      chk({tag, "_penable"}, 32'(penable),   32'h0);
      chk({tag, "_pwrite"},  32'(pwrite),    32'h0);
      chk({tag, "_paddr"},   32'(paddr),     32'h0);
      chk({tag, "_pwdata"},  32'(pwdata),    32'h0);
      chk({tag, "_rspv"},    32'(rsp_valid), 32'h0);
      chk({tag, "_rdata"},   32'(rsp_rdata), 32'h0);
      chk({tag, "_rerr"},    32'(rsp_err),   32'h0);
      chk({tag, "_ready"},   32'(req_ready), 32'h0);
   endtask

   task automatic idle_cycles(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         drive_noise();
         @(negedge pclk);
         chk("idle_rspv",    32'(rsp_valid), 32'h0);
         chk("idle_psel",    32'(psel),      32'h0);
         chk("idle_penable", 32'(penable),   32'h0);
         chk("idle_ready",   32'(req_ready), 32'h1);
      end
   endtask

   // Called at a negedge where the bridge is idle (or in a response cycle).
   // Returns at the negedge of the response cycle, with the response checked.
   task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int unsigned waits, input bit serr, input logic [DW-1:0] rd);
      int unsigned idx;
      int unsigned n_acc;
      bit          abort;
      logic [NS-1:0] sel;
      idx   = {30'd0, addr[AW-1 -: 2]};
      sel   = NS'(1 << idx);
      abort = (TO != 0) && (waits > TO);
      n_acc = abort ? TO + 1 : waits + 1;

      chk("accept_ready", 32'(req_ready), 32'h1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      drive_slave(idx, 1'b1, 1'b1, 16'($urandom));
      @(negedge pclk);

      chk("setup_psel",    32'(psel),      32'(sel));
      chk("setup_penable", 32'(penable),   32'h0);
      chk("setup_paddr",   32'(paddr),     32'(addr));
      chk("setup_pwdata",  32'(pwdata),    32'(wdata));
      chk("setup_pwrite",  32'(pwrite),    32'(wr));
      chk("setup_rspv",    32'(rsp_valid), 32'h0);
      chk("setup_ready",   32'(req_ready), 32'h0);
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      // Ready and error asserted during SETUP must be ignored.
      drive_slave(idx, 1'b1, 1'b1, 16'($urandom));

      for (int unsigned j = 0; j < n_acc; j++) begin
         @(negedge pclk);
         chk("acc_psel",    32'(psel),      32'(sel));
         chk("acc_penable", 32'(penable),   32'h1);
         chk("acc_paddr",   32'(paddr),     32'(addr));
         chk("acc_pwdata",  32'(pwdata),    32'(wdata));
         chk("acc_pwrite",  32'(pwrite),    32'(wr));
         chk("acc_rspv",    32'(rsp_valid), 32'h0);
         if (!abort && j == waits) drive_slave(idx, 1'b1, serr, rd);
         else                      drive_slave(idx, 1'b0, 1'b1, 16'($urandom));
      end

      @(negedge pclk);
      chk("rsp_valid",   32'(rsp_valid), 32'h1);
      chk("rsp_err",     32'(rsp_err),   32'(abort ? 1'b1 : serr));
      chk("rsp_rdata",   32'(rsp_rdata), (abort || wr) ? 32'h0 : 32'(rd));
      chk("rsp_psel",    32'(psel),      32'h0);
      chk("rsp_penable", 32'(penable),   32'h0);
      chk("rsp_ready",   32'(req_ready), 32'h1);
      chk("rsp_paddr",   32'(paddr),     32'(addr));
      chk("rsp_pwdata",  32'(pwdata),    32'(wdata));
      drive_noise();
   endtask

   initial begin
      longint t0;
      longint elapsed;
      int unsigned r;
      int unsigned w;

      preset_n  = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      drive_noise();
      repeat (3) @(negedge pclk);
      chk_outputs_zero("reset");
      preset_n = 1'b1;
      @(negedge pclk);
      chk("post_reset_ready", 32'(req_ready), 32'h1);
      chk("post_reset_rspv",  32'(rsp_valid), 32'h0);

      // Zero-wait write to slave 1; 3 cycles accept to response.
      t0 = longint'($time);
      do_txn(1'b1, 16'h4010, 16'hBEEF, 0, 1'b0, 16'h5555);
      elapsed = (longint'($time) - t0) / 10;
      chk("write_latency", 32'(elapsed), 32'd3);
      idle_cycles(1);

      // Read slave 3 with two waits; 5 cycles accept to response.
      t0 = longint'($time);
      do_txn(1'b0, 16'hC004, 16'h0000, 2, 1'b0, 16'h1234);
      elapsed = (longint'($time) - t0) / 10;
      chk("read2w_latency", 32'(elapsed), 32'd5);
      idle_cycles(2);

      // Slave errors, including pslverr high while pready low.
      do_txn(1'b0, 16'h0020, 16'h0000, 0, 1'b1, 16'hFFFF);
      idle_cycles(1);
      do_txn(1'b0, 16'h0100, 16'h0000, 3, 1'b0, 16'hABCD);
      idle_cycles(1);

      // Watchdog: slave 1 stalls; abort after 16 ACCESS cycles.
      t0 = longint'($time);
      do_txn(1'b0, 16'h4444, 16'h0000, 1000, 1'b0, 16'h7777);
      elapsed = (longint'($time) - t0) / 10;
      chk("timeout_latency", 32'(elapsed), 32'd18);
      idle_cycles(1);
      // Completion on the last allowed wait beats the watchdog; one more aborts.
      do_txn(1'b0, 16'h8888, 16'h0000, TO, 1'b0, 16'h0F0F);
      do_txn(1'b1, 16'h8890, 16'h1111, TO + 1, 1'b0, 16'h0F0F);
      idle_cycles(1);

      // Back-to-back: accept in each response cycle, 3 responses in 9 cycles.
      t0 = longint'($time);
      do_txn(1'b1, 16'h0002, 16'hA001, 0, 1'b0, 16'h0000);
      do_txn(1'b0, 16'h7FFE, 16'hA002, 0, 1'b0, 16'h5A5A);
      do_txn(1'b1, 16'hFFFF, 16'hA003, 0, 1'b0, 16'h0000);
      elapsed = (longint'($time) - t0) / 10;
      chk("b2b_cycles", 32'(elapsed), 32'd9);
      idle_cycles(1);

      // Random traffic, sometimes back-to-back.
      for (int unsigned k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         if (r < 6)       w = r;
         else if (r == 6) w = $urandom_range(TO - 1, TO + 2);
         else             w = 0;
         do_txn(1'($urandom), 16'($urandom), 16'($urandom), w,
                ($urandom_range(0, 3) == 0), 16'($urandom));
         if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
      end

      // Reset during a wait state drops the transfer.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 16'h8000;
      req_wdata = 16'h3C3C;
      @(negedge pclk);
      req_valid = 1'b0;
      pready    = '0;
      @(negedge pclk);
      chk("mid_acc_penable", 32'(penable), 32'h1);
      @(negedge pclk);
      preset_n = 1'b0;
      @(negedge pclk);
      chk_outputs_zero("mid_reset");
      preset_n = 1'b1;
      @(negedge pclk);
      chk("mid_release_ready", 32'(req_ready), 32'h1);
      chk("mid_release_rspv",  32'(rsp_valid), 32'h0);
      chk("mid_release_psel",  32'(psel),      32'h0);
      idle_cycles(2);
      do_txn(1'b0, 16'h8008, 16'h0000, 1, 1'b0, 16'h2468);
      idle_cycles(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
